// File: rtl/if_id_skid_buffer.sv
// if_id_skid_buffer
//   Two-entry skid buffer between fetch and decode. Carries {instruction,
//   address} with valid/ready handshakes on both sides, a synchronous flush
//   that empties the buffer (NOP on the outputs), and a saturating counter of
//   cycles where decode stalls a valid head entry.
//
// Ports
//   clock           in   rising-edge clock
//   reset_n         in   synchronous active-low reset
//   in_valid        in   fetch presents an instruction
//   in_ready        out  buffer can accept an entry (registered, occupancy != 2)
//   instruction_in  in   fetched instruction
//   instr_addr_in   in   fetch address
//   flush           in   synchronous flush, priority over push/pop
//   out_valid       out  head entry valid for decode
//   out_ready       in   decode consumes the head this cycle
//   instruction_out out  head instruction or NOP_INSTR when empty
//   instr_addr_out  out  head address or 0 when empty
//   occupancy       out  number of valid entries (0..2)
//   stall_count     out  saturating count of out_valid & ~out_ready cycles
module if_id_skid_buffer #(
    parameter int unsigned          INSTR_W   = 16,
    parameter int unsigned          ADDR_W    = 6,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = 16'h0000,
    parameter int unsigned          CNT_W     = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instruction_in,
    input  logic [ADDR_W-1:0]  instr_addr_in,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] instruction_out,
    output logic [ADDR_W-1:0]  instr_addr_out,
    output logic [1:0]         occupancy,
    output logic [CNT_W-1:0]   stall_count
);

    localparam int unsigned OCC_W = 2;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [INSTR_W-1:0] instr_mem_q [2];
    logic [INSTR_W-1:0] instr_mem_d [2];
    logic [ADDR_W-1:0]  addr_mem_q  [2];
    logic [ADDR_W-1:0]  addr_mem_d  [2];
    logic               head_q, head_d;
    logic               tail_q, tail_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [INSTR_W-1:0] out_instr_q, out_instr_d;
    logic [ADDR_W-1:0]  out_addr_q, out_addr_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic push_c;
    logic pop_c;

    // Handshake qualifiers; in_ready comes from a register, so no path from out_ready.
    assign push_c = in_valid & in_ready_q & ~flush;
    assign pop_c  = out_valid_q & out_ready & ~flush;

    // Next-state for storage, pointers, occupancy and the registered head view.
    always_comb begin
        instr_mem_d[0] = instr_mem_q[0];
        instr_mem_d[1] = instr_mem_q[1];
        addr_mem_d[0]  = addr_mem_q[0];
        addr_mem_d[1]  = addr_mem_q[1];
        head_d         = head_q;
        tail_d         = tail_q;
        occ_d          = occ_q;

        if (flush) begin
            head_d = 1'b0;
            tail_d = 1'b0;
            occ_d  = '0;
        end else begin
            if (push_c) begin
                instr_mem_d[tail_q] = instruction_in;
                addr_mem_d[tail_q]  = instr_addr_in;
                tail_d              = ~tail_q;
            end
            if (pop_c) begin
                head_d = ~head_q;
            end
            occ_d = occ_q + OCC_W'(push_c) - OCC_W'(pop_c);
        end

        // Outputs are registered copies of whatever will be the head next cycle.
        in_ready_d  = (occ_d != OCC_W'(2));
        out_valid_d = (occ_d != '0);
        out_instr_d = out_valid_d ? instr_mem_d[head_d] : NOP_INSTR;
        out_addr_d  = out_valid_d ? addr_mem_d[head_d]  : '0;
    end

    // Saturating stall counter; flush cycles are not counted as stalls.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && !out_ready && !flush && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            instr_mem_q[0] <= '0;
            instr_mem_q[1] <= '0;
            addr_mem_q[0]  <= '0;
            addr_mem_q[1]  <= '0;
            head_q         <= 1'b0;
            tail_q         <= 1'b0;
            occ_q          <= '0;
            in_ready_q     <= 1'b1;
            out_valid_q    <= 1'b0;
            out_instr_q    <= NOP_INSTR;
            out_addr_q     <= '0;
            stall_cnt_q    <= '0;
        end else begin
            instr_mem_q[0] <= instr_mem_d[0];
            instr_mem_q[1] <= instr_mem_d[1];
            addr_mem_q[0]  <= addr_mem_d[0];
            addr_mem_q[1]  <= addr_mem_d[1];
            head_q         <= head_d;
            tail_q         <= tail_d;
            occ_q          <= occ_d;
            in_ready_q     <= in_ready_d;
            out_valid_q    <= out_valid_d;
            out_instr_q    <= out_instr_d;
            out_addr_q     <= out_addr_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign in_ready        = in_ready_q;
    assign out_valid       = out_valid_q;
    assign instruction_out = out_instr_q;
    assign instr_addr_out  = out_addr_q;
    assign occupancy       = occ_q;
    assign stall_count     = stall_cnt_q;

endmodule

// File: tb/tb_if_id_skid_buffer.sv
// Directed bench for if_id_skid_buffer: default instance plus a CNT_W=3
// instance for counter saturation.
module tb_if_id_skid_buffer;

    logic        clock = 1'b0;
    logic        reset_n;

    logic        in_valid, flush, out_ready;
    logic [15:0] instruction_in;
    logic [5:0]  instr_addr_in;
    logic        in_ready, out_valid;
    logic [15:0] instruction_out;
    logic [5:0]  instr_addr_out;
    logic [1:0]  occupancy;
    logic [15:0] stall_count;

    logic        s_in_valid, s_flush, s_out_ready;
    logic [15:0] s_instruction_in;
    logic [5:0]  s_instr_addr_in;
    logic        s_in_ready, s_out_valid;
    logic [15:0] s_instruction_out;
    logic [5:0]  s_instr_addr_out;
    logic [1:0]  s_occupancy;
    logic [2:0]  s_stall_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    if_id_skid_buffer u_dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .instruction_in  (instruction_in),
        .instr_addr_in   (instr_addr_in),
        .flush           (flush),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .instruction_out (instruction_out),
        .instr_addr_out  (instr_addr_out),
        .occupancy       (occupancy),
        .stall_count     (stall_count)
    );

    if_id_skid_buffer #(.CNT_W(3)) u_sat (
        .clock           (clock),
        .reset_n         (reset_n),
        .in_valid        (s_in_valid),
        .in_ready        (s_in_ready),
        .instruction_in  (s_instruction_in),
        .instr_addr_in   (s_instr_addr_in),
        .flush           (s_flush),
        .out_valid       (s_out_valid),
        .out_ready       (s_out_ready),
        .instruction_out (s_instruction_out),
        .instr_addr_out  (s_instr_addr_out),
        .occupancy       (s_occupancy),
        .stall_count     (s_stall_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [1:0] occ, input logic ov,
                               input logic ir, input logic [15:0] instr,
                               input logic [5:0] addr, input logic [15:0] stall);
        check_eq({tag, ".occ"},   32'(occupancy),       32'(occ));
        check_eq({tag, ".ov"},    32'(out_valid),       32'(ov));
        check_eq({tag, ".ir"},    32'(in_ready),        32'(ir));
        check_eq({tag, ".instr"}, 32'(instruction_out), 32'(instr));
        check_eq({tag, ".addr"},  32'(instr_addr_out),  32'(addr));
        check_eq({tag, ".stall"}, 32'(stall_count),     32'(stall));
    endtask

    task automatic push(input logic [15:0] ins, input logic [5:0] a);
        in_valid       = 1'b1;
        instruction_in = ins;
        instr_addr_in  = a;
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        instruction_in = '0; instr_addr_in = '0;
        s_in_valid = 1'b0; s_flush = 1'b0; s_out_ready = 1'b1;
        s_instruction_in = '0; s_instr_addr_in = '0;

        // Reset then stream
        #2;
        tick(); tick();
        check_state("reset", 2'd0, 1'b0, 1'b1, 16'h0000, 6'd0, 16'd0);
        reset_n = 1'b1;
        push(16'h1234, 6'h05);
        tick();
        check_state("stream0", 2'd1, 1'b1, 1'b1, 16'h1234, 6'h05, 16'd0);
        push(16'hABCD, 6'h06);
        tick();
        check_state("stream1", 2'd1, 1'b1, 1'b1, 16'hABCD, 6'h06, 16'd0);
        in_valid = 1'b0;
        tick();
        check_state("stream_end", 2'd0, 1'b0, 1'b1, 16'h0000, 6'd0, 16'd0);

        // Backpressure fill
        out_ready = 1'b0;
        push(16'h1111, 6'd1);
        tick();
        check_state("fillA", 2'd1, 1'b1, 1'b1, 16'h1111, 6'd1, 16'd0);
        push(16'h2222, 6'd2);
        tick();
        check_state("fillB", 2'd2, 1'b1, 1'b0, 16'h1111, 6'd1, 16'd1);
        push(16'h3333, 6'd3);
        tick();
        check_state("held1", 2'd2, 1'b1, 1'b0, 16'h1111, 6'd1, 16'd2);
        tick();
        check_state("held2", 2'd2, 1'b1, 1'b0, 16'h1111, 6'd1, 16'd3);

        // Drain with simultaneous push
        out_ready = 1'b1;
        tick();
        check_state("drainB", 2'd1, 1'b1, 1'b1, 16'h2222, 6'd2, 16'd3);
        tick();
        check_state("drainC", 2'd1, 1'b1, 1'b1, 16'h3333, 6'd3, 16'd3);
        in_valid = 1'b0;
        tick();
        check_state("drained", 2'd0, 1'b0, 1'b1, 16'h0000, 6'd0, 16'd3);

        // Flush with push
        out_ready = 1'b0;
        push(16'h5555, 6'd7);
        tick();
        check_state("preflush", 2'd1, 1'b1, 1'b1, 16'h5555, 6'd7, 16'd3);
        flush = 1'b1;
        push(16'h4444, 6'd8);
        tick();
        check_state("flush", 2'd0, 1'b0, 1'b1, 16'h0000, 6'd0, 16'd3);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        check_state("postflush", 2'd0, 1'b0, 1'b1, 16'h0000, 6'd0, 16'd3);

        // Mid-operation reset at occupancy 2, stall 5
        push(16'h00A1, 6'd1);
        tick();
        push(16'h00B2, 6'd2);
        tick();
        in_valid = 1'b0;
        tick();
        check_state("prereset", 2'd2, 1'b1, 1'b0, 16'h00A1, 6'd1, 16'd5);
        reset_n = 1'b0;
        push(16'h00C3, 6'd3);
        tick();
        check_state("midreset", 2'd0, 1'b0, 1'b1, 16'h0000, 6'd0, 16'd0);
        reset_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check_state("afterreset", 2'd0, 1'b0, 1'b1, 16'h0000, 6'd0, 16'd0);

        // Counter saturation on the 3-bit instance
        s_in_valid = 1'b1; s_instruction_in = 16'h0077; s_instr_addr_in = 6'd2;
        tick();
        check_eq("sat.start", 32'(s_stall_count), 32'd0);
        s_in_valid = 1'b0; s_out_ready = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check_eq($sformatf("sat.cnt%0d", k), 32'(s_stall_count), 32'((k > 7) ? 7 : k));
        end
        check_eq("sat.occ",   32'(s_occupancy),       32'd1);
        check_eq("sat.instr", 32'(s_instruction_out), 32'h0077);
        check_eq("sat.addr",  32'(s_instr_addr_out),  32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
